// File: rtl/voltage_scan_ctrl_if.sv
// ADC DRP-style read channel between the scan controller (master) and the ADC (slave).
// One request pulse per channel read; the ADC answers with a data-valid strobe.
interface voltage_scan_ctrl_if;
  logic        adc_den;
  logic [6:0]  adc_daddr;
  logic        adc_drdy;
  logic [15:0] adc_do;

  modport master (
    output adc_den,
    output adc_daddr,
    input  adc_drdy,
    input  adc_do
  );

  modport slave (
    input  adc_den,
    input  adc_daddr,
    output adc_drdy,
    output adc_do
  );
endinterface

// File: rtl/voltage_scan_ctrl.sv
// Periodic ADC channel scanner: reads each channel, scales to millivolts, converts to four
// ASCII digits in a shadow bank and commits the whole frame atomically to the display bank.
module voltage_scan_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 65_000_000,
  parameter int unsigned N_CH           = 13,
  parameter logic [6:0]  CH_ADDR_BASE   = 7'h10,
  parameter int unsigned FULL_SCALE_MV  = 1000,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  voltage_scan_ctrl_if.master        adc,
  input  logic [3:0]                 rd_ch,
  output logic [27:0]                rd_ascii,
  output logic                       scan_busy,
  output logic                       frame_done,
  output logic [N_CH-1:0]            err_mask
);

  localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned ToW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [27:0] AsciiZero  = {4{7'h30}};
  localparam logic [27:0] AsciiDash  = {4{7'h2D}};
  localparam logic [27:0] AsciiSpace = {4{7'h20}};

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StScale,
    StBcd,
    StWrite,
    StCommit
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   refresh_q;
  logic              tick;
  logic [ChW-1:0]    ch_q;
  logic [ToW-1:0]    wait_q;
  logic              timeout_q;
  logic [11:0]       code_q;
  logic [13:0]       bin_q;
  logic [15:0]       bcd_q;
  logic [15:0]       bcd_adj;
  logic [3:0]        bit_q;
  logic [25:0]       prod;
  logic [27:0]       ascii_word;
  logic [27:0]       shadow_q  [N_CH];
  logic [27:0]       display_q [N_CH];
  logic [N_CH-1:0]   shadow_err_q;
  logic [N_CH-1:0]   err_mask_q;
  logic              frame_done_q;
  logic [27:0]       rd_ascii_q;
  logic              unused_bits;

  assign tick = (refresh_q == CntW'(REFRESH_CYCLES - 1));

  // Truncating scale: code/4096 of full scale, integer part only.
  assign prod = 26'(code_q) * 26'(FULL_SCALE_MV);

  // Double-dabble correction applied before every left shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  assign ascii_word = {3'b011, bcd_q[15:12], 3'b011, bcd_q[11:8],
                       3'b011, bcd_q[7:4],   3'b011, bcd_q[3:0]};

  // Low ADC nibble, the scaled fraction and the adjusted top bit are deliberately dropped.
  assign unused_bits = ^{adc.adc_do[3:0], prod[11:0], bcd_adj[15]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (tick) state_d = StReq;
      StReq:    state_d = StWait;
      StWait: begin
        if (adc.adc_drdy) begin
          state_d = StScale;
        end else if (wait_q == ToW'(TIMEOUT)) begin
          state_d = StWrite;
        end
      end
      StScale:  state_d = StBcd;
      StBcd:    if (bit_q == 4'd13) state_d = StWrite;
      StWrite:  state_d = (ch_q == ChW'(N_CH - 1)) ? StCommit : StReq;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      refresh_q    <= '0;
      ch_q         <= '0;
      wait_q       <= '0;
      timeout_q    <= 1'b0;
      code_q       <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      bit_q        <= '0;
      shadow_err_q <= '0;
      err_mask_q   <= '0;
      frame_done_q <= 1'b0;
      rd_ascii_q   <= AsciiZero;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i]  <= AsciiZero;
        display_q[i] <= AsciiZero;
      end
    end else begin
      state_q      <= state_d;
      refresh_q    <= tick ? '0 : refresh_q + 1'b1;
      frame_done_q <= (state_q == StCommit);

      // Reads sample the display before any same-edge commit lands.
      if (32'(rd_ch) < N_CH) begin
        rd_ascii_q <= display_q[rd_ch[ChW-1:0]];
      end else begin
        rd_ascii_q <= AsciiSpace;
      end

      case (state_q)
        StIdle: ch_q <= '0;
        StReq: begin
          wait_q    <= '0;
          timeout_q <= 1'b0;
        end
        StWait: begin
          if (adc.adc_drdy) begin
            code_q <= adc.adc_do[15:4];
          end else if (wait_q == ToW'(TIMEOUT)) begin
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StScale: begin
          bin_q <= prod[25:12];
          bcd_q <= '0;
          bit_q <= '0;
        end
        StBcd: begin
          bcd_q <= {bcd_adj[14:0], bin_q[13]};
          bin_q <= {bin_q[12:0], 1'b0};
          bit_q <= bit_q + 4'd1;
        end
        StWrite: begin
          shadow_q[ch_q]     <= timeout_q ? AsciiDash : ascii_word;
          shadow_err_q[ch_q] <= timeout_q;
          if (ch_q != ChW'(N_CH - 1)) ch_q <= ch_q + 1'b1;
        end
        StCommit: begin
          for (int i = 0; i < N_CH; i++) display_q[i] <= shadow_q[i];
          err_mask_q <= shadow_err_q;
        end
        default: ;
      endcase
    end
  end

  assign adc.adc_den   = (state_q == StReq);
  assign adc.adc_daddr = (state_q == StReq) ? CH_ADDR_BASE + 7'(ch_q) : 7'h00;
  assign scan_busy     = (state_q != StIdle);
  assign frame_done    = frame_done_q;
  assign err_mask      = err_mask_q;
  assign rd_ascii      = rd_ascii_q;

endmodule

// File: tb/tb_voltage_scan_ctrl.sv
// Bench for voltage_scan_ctrl: randomized ADC responder plus an arithmetic reference of the
// displayed digits, scan start times and per-channel timing.
module tb_voltage_scan_ctrl;

  localparam int unsigned Refresh   = 200;
  localparam int unsigned NCh       = 13;
  localparam int unsigned FullScale = 1000;
  localparam int unsigned Timeout   = 255;
  localparam logic [27:0] Zeros     = {4{7'h30}};
  localparam logic [27:0] Spaces    = {4{7'h20}};
  localparam logic [27:0] Dashes    = {4{7'h2D}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd_ch = 4'd0;
  logic [27:0] rd_ascii;
  logic        scan_busy;
  logic        frame_done;
  logic [12:0] err_mask;

  voltage_scan_ctrl_if adc_bus ();

  voltage_scan_ctrl #(
    .REFRESH_CYCLES (Refresh),
    .N_CH           (NCh),
    .CH_ADDR_BASE   (7'h10),
    .FULL_SCALE_MV  (FullScale),
    .TIMEOUT        (Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc        (adc_bus),
    .rd_ch      (rd_ch),
    .rd_ascii   (rd_ascii),
    .scan_busy  (scan_busy),
    .frame_done (frame_done),
    .err_mask   (err_mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference configuration of the simulated ADC.
  logic [11:0] codes  [NCh];
  bit          silent [NCh];
  int          delay_min = 3;
  int          delay_max = 3;
  bit          stray_en  = 1'b0;

  // Cycle index equal to the number of clocks since reset released (mod Refresh = refresh count).
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  logic [6:0]  den_addr_q [$];
  int          den_cyc_q  [$];
  int          den_wide = 0;
  int          fd_cnt   = 0;
  logic        den_prev = 1'b0;
  logic [27:0] rd_vals [16];

  always @(negedge clk) begin
    if (adc_bus.adc_den) begin
      den_addr_q.push_back(adc_bus.adc_daddr);
      den_cyc_q.push_back(cyc);
    end
    if (adc_bus.adc_den && den_prev) den_wide <= den_wide + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    den_prev <= adc_bus.adc_den;
  end

  // ADC responder: drdy a chosen number of cycles after den, plus stray strobes outside WAIT.
  initial begin
    int  cnt;
    int  rch;
    bit  waiting;
    cnt = 0;
    rch = 0;
    waiting = 1'b0;
    adc_bus.adc_drdy = 1'b0;
    adc_bus.adc_do   = 16'h0;
    forever begin
      @(negedge clk);
      adc_bus.adc_drdy = 1'b0;
      if (rst) begin
        cnt = 0;
        waiting = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            adc_bus.adc_drdy = 1'b1;
            adc_bus.adc_do   = {codes[rch], 4'($urandom)};
            waiting = 1'b0;
          end
        end else if (!waiting && stray_en && $urandom_range(7) == 0) begin
          adc_bus.adc_drdy = 1'b1;
          adc_bus.adc_do   = 16'($urandom);
        end
        if (adc_bus.adc_den) begin
          rch = int'(adc_bus.adc_daddr) - 16;
          waiting = 1'b1;
          if (stray_en && $urandom_range(3) == 0) begin
            adc_bus.adc_drdy = 1'b1;
            adc_bus.adc_do   = 16'($urandom);
          end
          if (rch >= 0 && rch < int'(NCh) && !silent[rch]) begin
            cnt = $urandom_range(delay_max, delay_min);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [27:0] exp_word(int ch);
    int mv;
    if (ch >= int'(NCh)) return Spaces;
    if (silent[ch]) return Dashes;
    mv = (int'(codes[ch]) * int'(FullScale)) / 4096;
    return {7'(48 + mv / 1000), 7'(48 + (mv / 100) % 10), 7'(48 + (mv / 10) % 10),
            7'(48 + mv % 10)};
  endfunction

  function automatic logic [12:0] exp_mask();
    logic [12:0] m;
    m = '0;
    for (int i = 0; i < int'(NCh); i++) m[i] = silent[i];
    return m;
  endfunction

  function automatic int next_start(int from_cyc);
    int t;
    t = from_cyc;
    while (t % int'(Refresh) != int'(Refresh) - 1) t++;
    return t + 1;
  endfunction

  task automatic read_all();
    for (int ch = 0; ch < 16; ch++) begin
      rd_ch = 4'(ch);
      @(negedge clk);
      rd_vals[ch] = rd_ascii;
    end
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Idle and far enough from the next tick that new ADC config applies to the whole next scan.
  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!scan_busy && (cyc % int'(Refresh)) < 150) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_ch = 4'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rd_ascii !== Zeros) begin
      n_fail++;
      $display("FAIL reset_rd_ascii: got %h required %h", rd_ascii, Zeros);
    end
    n_checks++;
    if (adc_bus.adc_den !== 1'b0 || scan_busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: den=%b busy=%b fd=%b required 0 0 0",
               adc_bus.adc_den, scan_busy, frame_done);
    end
    n_checks++;
    if (err_mask !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_err_mask: got %h required 0", err_mask);
    end
    rst = 1'b0;
    read_all();
    for (int ch = 0; ch < 16; ch++) begin
      n_checks++;
      if (rd_vals[ch] !== ((ch < int'(NCh)) ? Zeros : Spaces)) begin
        n_fail++;
        $display("FAIL reset_read ch%0d: got %h required %h", ch, rd_vals[ch],
                 (ch < int'(NCh)) ? Zeros : Spaces);
      end
    end
  endtask

  task automatic test_fixed_frame();
    bit ok;
    int base_den, base_fd, base_wide, exp_start;
    wait_quiet(ok);
    exp_start = next_start(cyc);
    for (int i = 0; i < int'(NCh); i++) begin
      codes[i]  = 12'($urandom);
      silent[i] = 1'b0;
    end
    codes[0] = 12'h000;
    codes[1] = 12'hFFF;
    codes[2] = 12'h16C;
    codes[3] = 12'h800;
    delay_min = 3;
    delay_max = 3;
    stray_en  = 1'b0;
    base_den  = den_addr_q.size();
    base_fd   = fd_cnt;
    base_wide = den_wide;
    rd_ch = 4'd2;
    wait_frame(2000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fixed_frame_done: got no frame_done within budget, required one");
    end
    n_checks++;
    if (rd_ascii !== Zeros) begin
      n_fail++;
      $display("FAIL commit_cycle_read: got %h required pre-commit %h", rd_ascii, Zeros);
    end
    @(negedge clk);
    n_checks++;
    if (rd_ascii !== exp_word(2) || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_commit_read: got %h fd=%b required %h fd=0",
               rd_ascii, frame_done, exp_word(2));
    end
    read_all();
    for (int ch = 0; ch < 16; ch++) begin
      n_checks++;
      if (rd_vals[ch] !== exp_word(ch)) begin
        n_fail++;
        $display("FAIL fixed_read ch%0d: got %h required %h", ch, rd_vals[ch], exp_word(ch));
      end
    end
    n_checks++;
    if (den_addr_q.size() - base_den != int'(NCh)) begin
      n_fail++;
      $display("FAIL fixed_den_count: got %0d required %0d", den_addr_q.size() - base_den, NCh);
    end else begin
      for (int i = 0; i < int'(NCh); i++) begin
        n_checks++;
        if (den_addr_q[base_den + i] !== 7'(16 + i)) begin
          n_fail++;
          $display("FAIL fixed_daddr %0d: got %h required %h", i, den_addr_q[base_den + i],
                   7'(16 + i));
        end
        if (i > 0) begin
          n_checks++;
          if (den_cyc_q[base_den + i] - den_cyc_q[base_den + i - 1] != 20) begin
            n_fail++;
            $display("FAIL fixed_den_spacing %0d: got %0d required 20", i,
                     den_cyc_q[base_den + i] - den_cyc_q[base_den + i - 1]);
          end
        end
      end
      n_checks++;
      if (den_cyc_q[base_den] != exp_start) begin
        n_fail++;
        $display("FAIL fixed_scan_start: got cycle %0d required %0d", den_cyc_q[base_den],
                 exp_start);
      end
    end
    n_checks++;
    if (den_wide != base_wide || fd_cnt - base_fd != 1) begin
      n_fail++;
      $display("FAIL fixed_pulses: wide_den=%0d frame_done=%0d required 0 and 1",
               den_wide - base_wide, fd_cnt - base_fd);
    end
    n_checks++;
    if (err_mask !== 13'h0 || scan_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_status: err_mask=%h busy=%b required 0 0", err_mask, scan_busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int base_den;
    wait_quiet(ok);
    for (int i = 0; i < int'(NCh); i++) begin
      codes[i]  = 12'($urandom);
      silent[i] = (i == 5);
    end
    delay_min = 3;
    delay_max = 3;
    stray_en  = 1'b1;
    base_den  = den_addr_q.size();
    wait_frame(4000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_frame_done: got no frame_done within budget, required one");
    end
    n_checks++;
    if (err_mask !== 13'h0020) begin
      n_fail++;
      $display("FAIL timeout_err_mask: got %h required 0020", err_mask);
    end
    read_all();
    for (int ch = 0; ch < 16; ch++) begin
      n_checks++;
      if (rd_vals[ch] !== exp_word(ch)) begin
        n_fail++;
        $display("FAIL timeout_read ch%0d: got %h required %h", ch, rd_vals[ch], exp_word(ch));
      end
    end
    n_checks++;
    if (den_addr_q.size() - base_den != int'(NCh)) begin
      n_fail++;
      $display("FAIL timeout_den_count: got %0d required %0d", den_addr_q.size() - base_den, NCh);
    end else begin
      n_checks++;
      if (den_cyc_q[base_den + 6] - den_cyc_q[base_den + 5] != int'(Timeout) + 3) begin
        n_fail++;
        $display("FAIL timeout_spacing: got %0d required %0d",
                 den_cyc_q[base_den + 6] - den_cyc_q[base_den + 5], Timeout + 3);
      end
    end
  endtask

  task automatic test_random_frames(input int n_frames);
    bit ok;
    bit seq_ok;
    int base_den, base_fd, exp_start;
    for (int f = 0; f < n_frames; f++) begin
      wait_quiet(ok);
      exp_start = next_start(cyc);
      for (int i = 0; i < int'(NCh); i++) begin
        case ($urandom_range(7))
          0:       codes[i] = 12'h000;
          1:       codes[i] = 12'hFFF;
          default: codes[i] = 12'($urandom);
        endcase
        silent[i] = 1'b0;
      end
      delay_min = 1;
      delay_max = 12;
      stray_en  = 1'b1;
      base_den  = den_addr_q.size();
      base_fd   = fd_cnt;
      wait_frame(3000, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_frame_done %0d: got no frame_done within budget, required one", f);
      end
      n_checks++;
      if (err_mask !== exp_mask()) begin
        n_fail++;
        $display("FAIL rand_err_mask %0d: got %h required %h", f, err_mask, exp_mask());
      end
      read_all();
      for (int ch = 0; ch < 16; ch++) begin
        n_checks++;
        if (rd_vals[ch] !== exp_word(ch)) begin
          n_fail++;
          $display("FAIL rand_read f%0d ch%0d: got %h required %h", f, ch, rd_vals[ch],
                   exp_word(ch));
        end
      end
      seq_ok = (den_addr_q.size() - base_den == int'(NCh));
      if (seq_ok) begin
        for (int i = 0; i < int'(NCh); i++) begin
          if (den_addr_q[base_den + i] !== 7'(16 + i)) seq_ok = 1'b0;
        end
      end
      n_checks++;
      if (!seq_ok || fd_cnt - base_fd != 1) begin
        n_fail++;
        $display("FAIL rand_scan_seq %0d: dens=%0d frame_done=%0d required 13 in order and 1",
                 f, den_addr_q.size() - base_den, fd_cnt - base_fd);
      end
      n_checks++;
      if (den_addr_q.size() <= base_den || den_cyc_q[base_den] != exp_start) begin
        n_fail++;
        $display("FAIL rand_scan_start %0d: got cycle %0d required %0d", f,
                 (den_cyc_q.size() > base_den) ? den_cyc_q[base_den] : -1, exp_start);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    int base_fd;
    wait_quiet(ok);
    for (int i = 0; i < int'(NCh); i++) begin
      codes[i]  = 12'($urandom);
      silent[i] = 1'b0;
    end
    delay_min = 3;
    delay_max = 3;
    stray_en  = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (adc_bus.adc_den && adc_bus.adc_daddr == 7'h17) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midreset_ch7_den: got no ch7 request within budget, required one");
    end
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (scan_busy !== 1'b0 || adc_bus.adc_den !== 1'b0 || err_mask !== 13'h0
        || rd_ascii !== Zeros) begin
      n_fail++;
      $display("FAIL midreset_state: busy=%b den=%b err=%h rd=%h required 0 0 0 %h",
               scan_busy, adc_bus.adc_den, err_mask, rd_ascii, Zeros);
    end
    rst = 1'b0;
    base_fd = fd_cnt;
    read_all();
    for (int ch = 0; ch < 16; ch++) begin
      n_checks++;
      if (rd_vals[ch] !== ((ch < int'(NCh)) ? Zeros : Spaces)) begin
        n_fail++;
        $display("FAIL midreset_read ch%0d: got %h required %h", ch, rd_vals[ch],
                 (ch < int'(NCh)) ? Zeros : Spaces);
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (adc_bus.adc_den) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok || adc_bus.adc_daddr !== 7'h10 || cyc != next_start(0)) begin
      n_fail++;
      $display("FAIL midreset_restart: seen=%b addr=%h cycle=%0d required 1 10 %0d",
               ok, adc_bus.adc_daddr, cyc, next_start(0));
    end
    n_checks++;
    if (fd_cnt != base_fd || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_frame: got %0d frame_done pulses required 0", fd_cnt - base_fd);
    end
    wait_frame(2000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midreset_frame_done: got no frame_done within budget, required one");
    end
    read_all();
    for (int ch = 0; ch < 16; ch++) begin
      n_checks++;
      if (rd_vals[ch] !== exp_word(ch)) begin
        n_fail++;
        $display("FAIL midreset_frame_read ch%0d: got %h required %h", ch, rd_vals[ch],
                 exp_word(ch));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NCh); i++) begin
      codes[i]  = 12'h000;
      silent[i] = 1'b0;
    end
    test_reset();
    test_fixed_frame();
    test_timeout();
    test_random_frames(3);
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
